mm_sequencer: RTL

- Parametrised command sequencer for the tiled matrix-multiply datapath. It sits between the host operation port and the block memories plus the systolic array.
- Accepts one multiply command per handshake and generates the bank/page selects, read-stream enables and switch pulses for X and W.
- Counts completed output tiles for the bulk write-back and reports done or err.
- Generalises the fixed 8x8, power-of-2 controller: independent M/N/K dimensions, any non-zero size, parametrised array size and bank count.

---
 rtl/mm_sequencer_if.sv | 27 ++
 rtl/mm_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mm_sequencer_if.sv
// mm_sequencer_if: command port of the matrix-multiply sequencer.
//   cmd_valid  host offers a command
//   cmd_ready  sequencer can take a command (IDLE)
//   cmd        [3:0] opcode, [7:4] A page, [11:8] B page, [15:12] C page,
//              [19:16] cfg {tA, tB, relu, acc}
//   dim_m/n/k  matrix dimensions, sampled when the command is taken
// The master modport is the host side; the slave modport is the sequencer side.
interface mm_sequencer_if #(
  parameter int DIM_W = 9
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd;
  logic [DIM_W-1:0] dim_m;
  logic [DIM_W-1:0] dim_n;
  logic [DIM_W-1:0] dim_k;

  modport master (
    output cmd_valid, cmd, dim_m, dim_n, dim_k,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd, dim_m, dim_n, dim_k,
    output cmd_ready
  );
endinterface

// File: rtl/mm_sequencer.sv
// mm_sequencer: command sequencer for the tiled matrix-multiply datapath.
// Takes one multiply command per handshake, latches the bank/page selects,
// streams K cells per line for every (X group, W group) pair, then waits for
// TM*TN output tiles from the systolic array before pulsing done.
//   clk, reset        clock, asynchronous active-high reset
//   enable            global enable; low freezes all state, strobes forced 0
//   bus               command port (mm_sequencer_if slave)
//   x/w/y_bank,_page  latched bank and page-in-bank selects
//   cfg               latched {tA, tB, relu, acc}
//   rd_en             X/W memories shift one cell this cycle
//   w_switch          last cell of the current W line group
//   x_switch          last W group of the current X group
//   ind_wc            cell index within the line, 0..K-1
//   tile_done         array reports one ARRAYxARRAY output tile
//   wr_en             tile_done accepted for write-back
//   busy, done, err   not idle / completion pulse / rejected-command pulse
module mm_sequencer #(
  parameter int ARRAY  = 8,
  parameter int NBANK  = 4,
  parameter int PAGE_W = 4,
  parameter int DIM_W  = 9
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  mm_sequencer_if.slave                     bus,
  output logic [$clog2(NBANK)-1:0]          x_bank,
  output logic [$clog2(NBANK)-1:0]          w_bank,
  output logic [$clog2(NBANK)-1:0]          y_bank,
  output logic [PAGE_W-$clog2(NBANK)-1:0]   x_page,
  output logic [PAGE_W-$clog2(NBANK)-1:0]   w_page,
  output logic [PAGE_W-$clog2(NBANK)-1:0]   y_page,
  output logic [3:0]                        cfg,
  output logic                              rd_en,
  output logic                              w_switch,
  output logic                              x_switch,
  output logic [DIM_W-1:0]                  ind_wc,
  input  logic                              tile_done,
  output logic                              wr_en,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int BANK_W = $clog2(NBANK);
  localparam int PIB_W  = PAGE_W - BANK_W;
  localparam int CNT_W  = 2 * DIM_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched command
  logic [BANK_W-1:0] r_x_bank, r_w_bank, r_y_bank;
  logic [PIB_W-1:0]  r_x_page, r_w_page, r_y_page;
  logic [3:0]        r_cfg;
  logic [DIM_W-1:0]  r_m, r_n, r_k;

  // Derived tile geometry and progress counters
  logic [DIM_W-1:0]  r_tm, r_tn;
  logic [CNT_W-1:0]  r_expected;
  logic [DIM_W-1:0]  r_wc, r_wl, r_xl;
  logic [CNT_W-1:0]  r_tiles;

  // Command decode
  logic [PAGE_W-1:0] w_a_page, w_b_page, w_c_page;
  logic [BANK_W-1:0] w_a_bank, w_b_bank, w_c_bank;
  logic              w_legal;
  logic              w_offer;
  logic              w_take;

  assign w_a_page = bus.cmd[4  +: PAGE_W];
  assign w_b_page = bus.cmd[8  +: PAGE_W];
  assign w_c_page = bus.cmd[12 +: PAGE_W];
  assign w_a_bank = w_a_page[PAGE_W-1 -: BANK_W];
  assign w_b_bank = w_b_page[PAGE_W-1 -: BANK_W];
  assign w_c_bank = w_c_page[PAGE_W-1 -: BANK_W];

  assign w_legal = (bus.cmd[3:0] == 4'd1)
                && (bus.dim_m != '0) && (bus.dim_n != '0) && (bus.dim_k != '0)
                && (w_a_bank != w_b_bank)
                && (w_c_bank != w_a_bank) && (w_c_bank != w_b_bank);

  // Every command offered in IDLE while enabled is consumed, legal or not.
  assign w_offer = enable && bus.cmd_valid && (r_state == S_IDLE);
  assign w_take  = w_offer && w_legal;

  // Ceiling division done once in LOAD; a partial tile still counts as a tile.
  logic [DIM_W:0]   w_m_up, w_n_up;
  logic [DIM_W-1:0] w_tm, w_tn;

  assign w_m_up = {1'b0, r_m} + (DIM_W+1)'(ARRAY - 1);
  assign w_n_up = {1'b0, r_n} + (DIM_W+1)'(ARRAY - 1);
  assign w_tm   = DIM_W'(w_m_up / (DIM_W+1)'(ARRAY));
  assign w_tn   = DIM_W'(w_n_up / (DIM_W+1)'(ARRAY));

  // Stream strobes
  logic w_rd_en, w_wsw, w_xsw, w_final;

  assign w_rd_en = enable && (r_state == S_STREAM);
  assign w_wsw   = w_rd_en && (r_wc == r_k  - DIM_W'(1));
  assign w_xsw   = w_wsw   && (r_wl == r_tn - DIM_W'(1));
  assign w_final = w_xsw   && (r_xl == r_tm - DIM_W'(1));

  // Tile accounting saturates at the expected count.
  logic             w_wr_en;
  logic [CNT_W-1:0] w_tiles_nxt;

  assign w_wr_en     = enable && tile_done
                    && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                    && (r_tiles < r_expected);
  assign w_tiles_nxt = r_tiles + CNT_W'(w_wr_en);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    err         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_take)  w_state_nxt = S_LOAD;
        if (w_offer && !w_legal) err = 1'b1;
      end
      S_LOAD:   w_state_nxt = S_STREAM;
      S_STREAM: if (w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_tiles_nxt == r_expected) begin
          w_state_nxt = S_IDLE;
          done        = enable;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_x_bank   <= '0;
      r_w_bank   <= '0;
      r_y_bank   <= '0;
      r_x_page   <= '0;
      r_w_page   <= '0;
      r_y_page   <= '0;
      r_cfg      <= '0;
      r_m        <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_tm       <= '0;
      r_tn       <= '0;
      r_expected <= '0;
      r_wc       <= '0;
      r_wl       <= '0;
      r_xl       <= '0;
      r_tiles    <= '0;
    end else if (enable) begin
      r_state <= (r_state == S_IDLE && !w_take) ? S_IDLE : w_state_nxt;

      if (w_take) begin
        r_x_bank <= w_a_bank;
        r_w_bank <= w_b_bank;
        r_y_bank <= w_c_bank;
        r_x_page <= w_a_page[PIB_W-1:0];
        r_w_page <= w_b_page[PIB_W-1:0];
        r_y_page <= w_c_page[PIB_W-1:0];
        r_cfg    <= bus.cmd[19:16];
        r_m      <= bus.dim_m;
        r_n      <= bus.dim_n;
        r_k      <= bus.dim_k;
      end

      if (r_state == S_LOAD) begin
        r_tm       <= w_tm;
        r_tn       <= w_tn;
        r_expected <= CNT_W'(w_tm) * CNT_W'(w_tn);
        r_wc       <= '0;
        r_wl       <= '0;
        r_xl       <= '0;
        r_tiles    <= '0;
      end

      // Nested wrap counters: cell -> W group -> X group.
      if (w_rd_en) begin
        r_wc <= w_wsw ? '0 : r_wc + DIM_W'(1);
        if (w_wsw)   r_wl <= w_xsw   ? '0 : r_wl + DIM_W'(1);
        if (w_xsw)   r_xl <= w_final ? '0 : r_xl + DIM_W'(1);
      end

      if (w_wr_en) r_tiles <= w_tiles_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign rd_en         = w_rd_en;
  assign w_switch      = w_wsw;
  assign x_switch      = w_xsw;
  assign wr_en         = w_wr_en;
  assign ind_wc        = r_wc;
  assign x_bank        = r_x_bank;
  assign w_bank        = r_w_bank;
  assign y_bank        = r_y_bank;
  assign x_page        = r_x_page;
  assign w_page        = r_w_page;
  assign y_page        = r_y_page;
  assign cfg           = r_cfg;

  // Command bits [31:20] are reserved.
  logic w_unused;
  assign w_unused = &{1'b0, bus.cmd[31:20]};

endmodule
